// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared declarations for the data-memory responder:
//   - state_t          : responder FSM states (IDLE, WAIT, RESP)
//   - LAT_W            : width of the wait-cycle counter (covers LATENCY 1..15)
//   - word_index_width : number of word-index bits for a given word depth
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int LAT_W = 4;

    // Word-index width for a power-of-two word depth.
    function automatic int word_index_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/ram_sp.sv
// -----------------------------------------------------------------------------
// ram_sp
// Single-port word array: synchronous write, combinational read, one shared
// address for both. Contents are never initialised or cleared.
// Ports:
//   clk    in   1      write clock
//   we     in   1      write enable (write happens on rising edge)
//   addr   in   IDX_W  word index
//   wdata  in   32     write data
//   rdata  out  32     word currently stored at addr
// -----------------------------------------------------------------------------
module ram_sp #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];

    // Synchronous word write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the processor data port. A request accepted in
// IDLE is held for LATENCY cycles, then the store is committed or the load
// data is returned, with a single-cycle ack.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   LATENCY      cycles from acceptance edge to ack rising edge (1..15)
// Ports:
//   clk    in   1   system clock
//   reset  in   1   synchronous active-high reset
//   req    in   1   request valid, sampled only in IDLE
//   we     in   1   1 = store, 0 = load (sampled with req)
//   addr   in   32  byte address (sampled with req)
//   wdata  in   32  store data (sampled with req)
//   ack    out  1   one-cycle completion pulse
//   err    out  1   access rejected (valid with ack)
//   rdata  out  32  load data, held until the next ack
//   busy   out  1   access in flight
// Build option:
//   ALIGN_CHECK_EN  when defined, addr[1:0] != 0 rejects the access;
//                   otherwise misaligned addresses hit the containing word.
//
// Timing: the FSM spends LATENCY-1 cycles in WAIT and one in RESP; ack/err
// and rdata are registered on the edge that leaves RESP, so they appear at
// E0+LATENCY. The store commits on that same edge. The cycle carrying ack
// is already IDLE, so a held-high req is re-accepted at E0+LATENCY+1 and
// busy stays high across back-to-back accesses.
// -----------------------------------------------------------------------------
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        busy
);

    localparam int IDX_W = word_index_width(DEPTH_WORDS);

    state_t             state_r;
    logic [LAT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic               we_r;
    logic [31:0]        wdata_r;
    logic               reject_r;
    logic               ack_r;
    logic               err_r;
    logic [31:0]        rdata_r;
    logic               busy_r;

    logic               reject_s;
    logic               ram_we_s;
    logic [31:0]        ram_rdata_s;

    // Rejection of the address currently on the request bus.
    always_comb begin
        reject_s = 1'b0;
        if ((addr >> (IDX_W + 2)) != 32'd0) begin
            reject_s = 1'b1;
        end
`ifdef ALIGN_CHECK_EN
        else if (addr[1:0] != 2'b00) begin
            reject_s = 1'b1;
        end
`endif
        else begin
            reject_s = 1'b0;
        end
    end

    // Store commit on the edge leaving RESP; a reset on that edge aborts it.
    always_comb begin
        ram_we_s = 1'b0;
        if ((state_r == RESP) && we_r && !reject_r && !reset) begin
            ram_we_s = 1'b1;
        end else begin
            ram_we_s = 1'b0;
        end
    end

    ram_sp #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (idx_r),
        .wdata (wdata_r),
        .rdata (ram_rdata_s)
    );

    // Responder FSM with wait counter, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= {LAT_W{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            we_r     <= 1'b0;
            wdata_r  <= 32'd0;
            reject_r <= 1'b0;
            ack_r    <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= 32'd0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack_r <= 1'b0;
                    err_r <= 1'b0;
                    if (req) begin
                        idx_r    <= addr[IDX_W+1:2];
                        we_r     <= we;
                        wdata_r  <= wdata;
                        reject_r <= reject_s;
                        cnt_r    <= LAT_W'(LATENCY - 1);
                        busy_r   <= 1'b1;
                        state_r  <= (LATENCY == 1) ? RESP : WAIT;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                WAIT: begin
                    // Counter was loaded with LATENCY-1 (>= 1 here); reaching
                    // zero means the response cycle is next.
                    cnt_r <= cnt_r - LAT_W'(1);
                    if (cnt_r == LAT_W'(1)) begin
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    ack_r   <= 1'b1;
                    err_r   <= reject_r;
                    if (reject_r) begin
                        rdata_r <= 32'd0;
                    end else if (!we_r) begin
                        rdata_r <= ram_rdata_s;
                    end else begin
                        rdata_r <= rdata_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ack   = ack_r;
    assign err   = err_r;
    assign rdata = rdata_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Self-checking bench for data_mem_responder (DEPTH_WORDS=64, LATENCY=2).
// Reference model: a plain word array plus the last returned load value.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        busy;

    int n_checks;
    int n_pass;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rd;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ack   (ack),
        .err   (err),
        .rdata (rdata),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    function automatic logic ref_reject(input logic [31:0] a);
        logic r;
        r = (a >= 32'(DEPTH * 4));
`ifdef ALIGN_CHECK_EN
        if ((a % 32'd4) != 32'd0) r = 1'b1;
`endif
        return r;
    endfunction

    // One complete access; inputs are scrambled while it is in flight.
    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic        rej;
        int          ix;
        logic [31:0] exp_rd;
        rej = ref_reject(a);
        ix  = int'((a / 32'd4) % 32'(DEPTH));
        if (rej)      exp_rd = 32'd0;
        else if (w)   exp_rd = model_rd;
        else          exp_rd = model_mem[ix];
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        check("busy_at_accept", {31'd0, busy}, 32'd1);
        check("ack_at_accept", {31'd0, ack}, 32'd0);
        req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk); #1;
            check("ack_timing", {31'd0, ack}, (k == LAT) ? 32'd1 : 32'd0);
            check("busy_inflight", {31'd0, busy}, 32'd1);
            addr = $urandom; wdata = $urandom;
            if (k == LAT) begin
                check("err", {31'd0, err}, {31'd0, rej});
                check("rdata", rdata, exp_rd);
            end
        end
        if (w && !rej) model_mem[ix] = d;
        model_rd = exp_rd;
        @(posedge clk); #1;
        check("ack_falls", {31'd0, ack}, 32'd0);
        check("busy_falls", {31'd0, busy}, 32'd0);
        check("rdata_held", rdata, exp_rd);
    endtask

    initial begin
        logic [31:0] hd [4];
        logic [31:0] a;
        n_checks = 0;
        n_pass   = 0;
        model_rd = 32'd0;
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        reset = 1'b0;

        // Fill every word so later loads have defined contents.
        for (int i = 0; i < DEPTH; i++) do_access(1'b1, 32'(i * 4), $urandom);

        // Store then load.
        do_access(1'b1, 32'h10, 32'hDEADBEEF);
        do_access(1'b0, 32'h10, 32'h0);

        // Out-of-range load, then the in-range word is untouched.
        do_access(1'b0, 32'h100, 32'h0);
        do_access(1'b1, 32'h8000_0040, 32'h0BAD_0BAD);
        do_access(1'b0, 32'h10, 32'h0);
        do_access(1'b0, 32'h40, 32'h0);

        // Misaligned store, then read the containing word.
        do_access(1'b1, 32'h22, 32'h12345678);
        do_access(1'b0, 32'h20, 32'h0);

        // Reset one cycle into WAIT aborts the store.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h08; wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_ack", {31'd0, ack}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        model_rd = 32'd0;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("abort_no_ack", {31'd0, ack}, 32'd0);
        end
        do_access(1'b0, 32'h08, 32'h0);

        // req held high: back-to-back stores every LAT+1 cycles.
        for (int i = 0; i < 4; i++) hd[i] = $urandom;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h00; wdata = hd[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("held_busy_accept", {31'd0, busy}, 32'd1);
            check("held_ack_accept", {31'd0, ack}, 32'd0);
            model_mem[i] = hd[i];
            if (i < 3) begin
                addr = 32'((i + 1) * 4); wdata = hd[i + 1];
            end else begin
                req = 1'b0;
            end
            for (int k = 1; k <= LAT; k++) begin
                @(posedge clk); #1;
                check("held_ack", {31'd0, ack}, (k == LAT) ? 32'd1 : 32'd0);
                check("held_busy", {31'd0, busy}, 32'd1);
                if (k == LAT) begin
                    check("held_err", {31'd0, err}, 32'd0);
                    check("held_rdata", rdata, model_rd);
                end
            end
        end
        @(posedge clk); #1;
        check("held_busy_end", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) do_access(1'b0, 32'(i * 4), 32'h0);

        // Random mixed traffic.
        for (int i = 0; i < 80; i++) begin
            a = 32'($urandom_range(0, DEPTH * 4 - 1));
            if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(8, 31));
            do_access(1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
